// File: rtl/mips_pkg.sv
// Shared MIPS datapath widths and the writeback request payload.
package mips_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_COUNT  = 32;
   localparam int unsigned WAIT_W     = 4;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wr_req_t;

   // One-hot register select, all-zero when the source is idle.
   function automatic logic [REG_COUNT-1:0] addr_onehot(input logic                  en,
                                                        input logic [REG_ADDR_W-1:0] a);
      return en ? (REG_COUNT'(1) << a) : '0;
   endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive cycles a requester has lost arbitration.
module starve_counter
   import mips_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 3
)
(
   input  logic clk,
   input  logic resetN,
   input  logic clr_i,
   input  logic inc_i,
   output logic saturated
);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < WAIT_W'(MAX_WAIT))) begin
         cnt_d = cnt_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign saturated = (cnt_q >= WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/regwrite_arbiter.sv
// Arbitrates the ALU and load writeback sources onto the single register-file
// write port, with a starvation override and a pending-write hazard mask.
module regwrite_arbiter
   import mips_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 3
)
(
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  aluValid,
   input  logic [REG_ADDR_W-1:0] aluAddress,
   input  logic [DATA_W-1:0]     aluData,
   output logic                  aluReady,
   input  logic                  memValid,
   input  logic [REG_ADDR_W-1:0] memAddress,
   input  logic [DATA_W-1:0]     memData,
   output logic                  memReady,
   output logic                  regWrite,
   output logic [REG_ADDR_W-1:0] address,
   output logic [DATA_W-1:0]     data,
   output logic [REG_COUNT-1:0]  pendingMask
);

   wr_req_t               alu_req, mem_req;
   logic                  saturated;
   logic                  force_alu;
   logic                  reg_write_q, reg_write_d;
   logic [REG_ADDR_W-1:0] address_q, address_d;
   logic [DATA_W-1:0]     data_q, data_d;

   assign alu_req = '{valid: aluValid, addr: aluAddress, data: aluData};
   assign mem_req = '{valid: memValid, addr: memAddress, data: memData};

   // Same-address override is suppressed so the younger ALU value lands last.
   assign force_alu = saturated && ((alu_req.addr != mem_req.addr) || !mem_req.valid);
   assign memReady  = resetN && mem_req.valid && !force_alu;
   assign aluReady  = resetN && alu_req.valid && (!mem_req.valid || force_alu);

   starve_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_counter (
      .clk       (clk),
      .resetN    (resetN),
      .clr_i     (!alu_req.valid || aluReady),
      .inc_i     (alu_req.valid && !aluReady),
      .saturated (saturated)
   );

   // Output stage: capture the granted request; writes to $zero are dropped.
   always_comb begin
      reg_write_d = 1'b0;
      address_d   = address_q;
      data_d      = data_q;
      if (memReady) begin
         reg_write_d = (mem_req.addr != '0);
         address_d   = mem_req.addr;
         data_d      = mem_req.data;
      end else if (aluReady) begin
         reg_write_d = (alu_req.addr != '0);
         address_d   = alu_req.addr;
         data_d      = alu_req.data;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         reg_write_q <= 1'b0;
         address_q   <= '0;
         data_q      <= '0;
      end else begin
         reg_write_q <= reg_write_d;
         address_q   <= address_d;
         data_q      <= data_d;
      end
   end

   assign regWrite = reg_write_q;
   assign address  = address_q;
   assign data     = data_q;

   assign pendingMask = (addr_onehot(alu_req.valid, alu_req.addr) |
                         addr_onehot(mem_req.valid, mem_req.addr) |
                         addr_onehot(reg_write_q, address_q)) & ~REG_COUNT'(1);

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed and randomized checks of regwrite_arbiter against a behavioural model.
module tb_regwrite_arbiter;

   localparam int MAX_WAIT = 3;

   logic        clk = 1'b0;
   logic        resetN;
   logic        aluValid, memValid;
   logic [4:0]  aluAddress, memAddress;
   logic [31:0] aluData, memData;
   logic        aluReady, memReady, regWrite;
   logic [4:0]  address;
   logic [31:0] data;
   logic [31:0] pendingMask;

   regwrite_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk         (clk),
      .resetN      (resetN),
      .aluValid    (aluValid),
      .aluAddress  (aluAddress),
      .aluData     (aluData),
      .aluReady    (aluReady),
      .memValid    (memValid),
      .memAddress  (memAddress),
      .memData     (memData),
      .memReady    (memReady),
      .regWrite    (regWrite),
      .address     (address),
      .data        (data),
      .pendingMask (pendingMask)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model: the write port contents and how many cycles in a row the ALU has lost.
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_lost;

   logic        e_alu_rdy, e_mem_rdy;
   logic [31:0] e_mask;
   logic        alu_xfer, mem_xfer;

   logic        o_alu_rdy, o_mem_rdy, o_we;
   logic [4:0]  o_addr;
   logic [31:0] o_data, o_mask;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_lost = 0;
   endfunction

   function automatic void predict();
      bit force_alu;
      force_alu = (m_lost >= MAX_WAIT) && ((aluAddress != memAddress) || !memValid);
      e_mem_rdy = resetN && memValid && !force_alu;
      e_alu_rdy = resetN && aluValid && (!memValid || force_alu);
      e_mask = '0;
      for (int i = 1; i < 32; i++) begin
         if ((aluValid && aluAddress == 5'(i)) || (memValid && memAddress == 5'(i)) ||
             (m_we && m_addr == 5'(i)))
            e_mask[i] = 1'b1;
      end
   endfunction

   // One clock: check at the falling edge, advance the model at the rising edge.
   task automatic cycle(input string tag);
      predict();
      @(negedge clk);
      o_alu_rdy = aluReady;
      o_mem_rdy = memReady;
      o_we      = regWrite;
      o_addr    = address;
      o_data    = data;
      o_mask    = pendingMask;
      chk({tag, ".memReady"},    32'(memReady),          32'(e_mem_rdy));
      chk({tag, ".aluReady"},    32'(aluReady),          32'(e_alu_rdy));
      chk({tag, ".oneReady"},    32'(aluReady & memReady), 32'(0));
      chk({tag, ".regWrite"},    32'(regWrite),          32'(m_we));
      chk({tag, ".address"},     32'(address),           32'(m_addr));
      chk({tag, ".data"},        data,                   m_data);
      chk({tag, ".pendingMask"}, pendingMask,            e_mask);
      @(posedge clk);
      alu_xfer = e_alu_rdy;
      mem_xfer = e_mem_rdy;
      if (!resetN) begin
         model_reset();
      end else begin
         if (mem_xfer) begin
            m_we = (memAddress != 5'd0); m_addr = memAddress; m_data = memData;
         end else if (alu_xfer) begin
            m_we = (aluAddress != 5'd0); m_addr = aluAddress; m_data = aluData;
         end else begin
            m_we = 1'b0;
         end
         if (!aluValid || alu_xfer) m_lost = 0;
         else if (m_lost < MAX_WAIT) m_lost++;
      end
      #1;
   endtask

   initial begin
      int n;
      resetN = 1'b0;
      aluValid = 1'b1; aluAddress = 5'd2; aluData = 32'h1;
      memValid = 1'b1; memAddress = 5'd6; memData = 32'h2;
      alu_xfer = 1'b0; mem_xfer = 1'b0;
      model_reset();

      // Reset: readies held low even with requests present.
      cycle("reset0");
      cycle("reset1");
      chk("reset.regWrite", 32'(o_we), 32'(0));
      chk("reset.aluReady", 32'(o_alu_rdy), 32'(0));
      resetN = 1'b1;
      aluValid = 1'b0; memValid = 1'b0;
      cycle("idle");

      // Single load.
      memValid = 1'b1; memAddress = 5'd5; memData = 32'hDEADBEEF;
      cycle("load");
      chk("load.ready", 32'(o_mem_rdy), 32'(1));
      chk("load.mask5a", 32'(o_mask[5]), 32'(1));
      memValid = 1'b0;
      cycle("load_wr");
      chk("load.we", 32'(o_we), 32'(1));
      chk("load.addr", 32'(o_addr), 32'(5));
      chk("load.data", o_data, 32'hDEADBEEF);
      chk("load.mask5b", 32'(o_mask[5]), 32'(1));
      cycle("load_done");
      chk("load.mask5c", 32'(o_mask[5]), 32'(0));

      // Collision: load first, then ALU.
      aluValid = 1'b1; aluAddress = 5'd3; aluData = 32'h11;
      memValid = 1'b1; memAddress = 5'd4; memData = 32'h22;
      cycle("coll0");
      chk("coll.memFirst", 32'(o_mem_rdy), 32'(1));
      memValid = 1'b0;
      cycle("coll1");
      chk("coll.aluSecond", 32'(o_alu_rdy), 32'(1));
      chk("coll.addr4", 32'(o_addr), 32'(4));
      chk("coll.data22", o_data, 32'h22);
      aluValid = 1'b0;
      cycle("coll2");
      chk("coll.addr3", 32'(o_addr), 32'(3));
      chk("coll.data11", o_data, 32'h11);

      // Starvation under continuous load traffic to another register.
      aluValid = 1'b1; aluAddress = 5'd8; aluData = 32'hAAAA_0008;
      memAddress = 5'd7;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         memValid = 1'b1; memData = $urandom;
         cycle("starve");
         n++;
         if (o_alu_rdy) break;
      end
      chk("starve.grantCycle", 32'(n), 32'(4));
      chk("starve.memBlocked", 32'(o_mem_rdy), 32'(0));
      aluValid = 1'b0;
      cycle("starve_drain0");
      memValid = 1'b0;
      cycle("starve_drain1");

      // Same-address suppression.
      aluValid = 1'b1; aluAddress = 5'd9; aluData = 32'h9999_9999;
      memValid = 1'b1; memAddress = 5'd7;
      for (int i = 0; i < 3; i++) begin
         memData = $urandom;
         cycle("same_pre");
      end
      memAddress = 5'd9; memData = 32'h1234_5678;
      cycle("same0");
      chk("same.memFirst", 32'(o_mem_rdy), 32'(1));
      chk("same.aluHeld", 32'(o_alu_rdy), 32'(0));
      memValid = 1'b0;
      cycle("same1");
      chk("same.aluNext", 32'(o_alu_rdy), 32'(1));
      aluValid = 1'b0;
      cycle("same2");
      chk("same.finalAddr", 32'(o_addr), 32'(9));
      chk("same.finalData", o_data, 32'h9999_9999);

      // Write to $zero is accepted and dropped.
      aluValid = 1'b1; aluAddress = 5'd0; aluData = 32'h55;
      cycle("zero0");
      chk("zero.ready", 32'(o_alu_rdy), 32'(1));
      chk("zero.mask0", o_mask, 32'(0));
      aluValid = 1'b0;
      cycle("zero1");
      chk("zero.we", 32'(o_we), 32'(0));
      chk("zero.mask1", o_mask, 32'(0));

      // Asynchronous reset while a write is on the port.
      memValid = 1'b1; memAddress = 5'd12; memData = 32'h0000_CAFE;
      cycle("mid0");
      memValid = 1'b0;
      #2;
      chk("mid.weBefore", 32'(regWrite), 32'(1));
      resetN = 1'b0;
      aluValid = 1'b1; aluAddress = 5'd1; memValid = 1'b1; memAddress = 5'd2;
      #1;
      chk("mid.we", 32'(regWrite), 32'(0));
      chk("mid.addr", 32'(address), 32'(0));
      chk("mid.data", data, 32'(0));
      chk("mid.aluReady", 32'(aluReady), 32'(0));
      chk("mid.memReady", 32'(memReady), 32'(0));
      model_reset();
      cycle("mid_rst");
      resetN = 1'b1;
      aluValid = 1'b0;
      memAddress = 5'd13; memData = 32'h0000_BEEF;
      cycle("mid1");
      chk("mid.reaccept", 32'(o_mem_rdy), 32'(1));
      memValid = 1'b0;
      cycle("mid2");
      chk("mid.addr13", 32'(o_addr), 32'(13));
      chk("mid.dataBeef", o_data, 32'h0000_BEEF);

      // Random traffic honouring the hold-until-transfer rule.
      for (int k = 0; k < 600; k++) begin
         if (!(aluValid && !alu_xfer)) begin
            aluValid   = ($urandom_range(0, 3) != 0);
            aluAddress = 5'($urandom_range(0, 7));
            aluData    = $urandom;
         end
         if (!(memValid && !mem_xfer)) begin
            memValid   = ($urandom_range(0, 2) != 0);
            memAddress = 5'($urandom_range(0, 7));
            memData    = $urandom;
         end
         cycle("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
